// File: rtl/cache_set_assoc_ctrl_if.sv
// CPU and backing-memory bus bundle for the set-associative cache controller.
// master: CPU/memory side; slave: controller side.
interface cache_set_assoc_ctrl_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_done;
  logic [7:0] cpu_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata, mem_ack,
    input  cpu_done, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_ack,
    output cpu_done, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_set_assoc_ctrl.sv
// 2-way, 2-line, 8-byte-block cache controller; write-through, no-write-allocate.
// Define CACHE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_set_assoc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  cache_set_assoc_ctrl_if.slave bus,
  output logic [7:0] cache_data,
  output logic       cache_rdline,
  output logic [2:0] cache_rdoffset,
  output logic       cache_rdentry,
  output logic       cache_wrline,
  output logic [2:0] cache_wroffset,
  output logic       cache_wrentry,
  output logic       cache_wren,
  input  logic [7:0] cache_q
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD,
    S_FILL,
    S_WMEM,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [2:0] cnt_q, cnt_d;
  logic       way_q, way_d;
  logic       hit_q, hit_d;
  logic       first_q, first_d;

  // indexed [way][line]
  logic [1:0][1:0]      valid_q, valid_d;
  logic [1:0][1:0][3:0] tag_q, tag_d;
  logic [1:0]           lru_q, lru_d;

  logic       line;
  logic [3:0] ltag;
  logic       hit0;
  logic       hit1;
  logic       hit;
  logic       hway;
  logic       victim;

  assign line = addr_q[3];
  assign ltag = addr_q[7:4];
  assign hit0 = valid_q[0][line] && (tag_q[0][line] == ltag);
  assign hit1 = valid_q[1][line] && (tag_q[1][line] == ltag);
  assign hit  = hit0 | hit1;
  assign hway = ~hit0;

  always_comb begin
    victim = lru_q[line];
    if (!valid_q[0][line]) begin
      victim = 1'b0;
    end else if (!valid_q[1][line]) begin
      victim = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      way_q   <= 1'b0;
      hit_q   <= 1'b0;
      first_q <= 1'b0;
      valid_q <= '0;
      tag_q   <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      first_q <= first_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      lru_q   <= lru_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    way_d   = way_q;
    hit_d   = hit_q;
    first_d = first_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    lru_d   = lru_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          first_d = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        first_d = 1'b0;
        way_d   = hway;
        hit_d   = hit;
        // LRU names the way that did not hit
        if (hit) begin
          lru_d[line] = hit0;
        end
        if (we_q) begin
          state_d = S_WMEM;
        end else if (hit) begin
          state_d = S_RD;
        end else begin
          way_d                = victim;
          valid_d[victim][line] = 1'b0;
          tag_d[victim][line]   = ltag;
          cnt_d                = '0;
          state_d              = S_FILL;
        end
      end
      S_RD: begin
        rdata_d = cache_q;
        state_d = S_DONE;
      end
      S_FILL: begin
        if (bus.mem_ack) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            valid_d[way_q][line] = 1'b1;
            state_d              = S_LOOKUP;
          end
        end
      end
      S_WMEM: begin
        if (bus.mem_ack) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.cpu_rdata = rdata_q;

  always_comb begin
    bus.cpu_done   = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    cache_data     = '0;
    cache_rdline   = 1'b0;
    cache_rdoffset = '0;
    cache_rdentry  = 1'b0;
    cache_wrline   = 1'b0;
    cache_wroffset = '0;
    cache_wrentry  = 1'b0;
    cache_wren     = 1'b0;
    unique case (state_q)
      S_LOOKUP: begin
        cache_rdline   = line;
        cache_rdoffset = addr_q[2:0];
        cache_rdentry  = hway;
      end
      S_RD: begin
        cache_rdline   = line;
        cache_rdoffset = addr_q[2:0];
        cache_rdentry  = way_q;
      end
      S_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_q[7:3], cnt_q};
        if (bus.mem_ack) begin
          cache_wren     = 1'b1;
          cache_wrentry  = way_q;
          cache_wrline   = line;
          cache_wroffset = cnt_q;
          cache_data     = bus.mem_rdata;
        end
      end
      S_WMEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        if (bus.mem_ack && hit_q) begin
          cache_wren     = 1'b1;
          cache_wrentry  = way_q;
          cache_wrline   = line;
          cache_wroffset = addr_q[2:0];
          cache_data     = wdata_q;
        end
      end
      S_DONE: begin
        bus.cpu_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // only the first lookup of a request counts
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP && first_q) begin
      if (hit) begin
        if (hit_cnt_q != 16'hFFFF) begin
          hit_cnt_d = hit_cnt_q + 16'd1;
        end
      end else if (miss_cnt_q != 16'hFFFF) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
